// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the sequence detector: words in over valid/ready,
// bits out MSB first on x, with a one-word holding register for gapless streaming.
module seq_serializer #(
    parameter int WIDTH = 8,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             en,
    output logic             x,
    output logic             x_valid,
    output logic             done,
    output logic [7:0]       words
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_hold;
    logic [CW-1:0]    r_cnt;
    logic             r_hold_full;
    logic             r_done;
    logic [7:0]       r_words;

    logic w_xfer;
    logic w_adv;
    logic w_last;
    logic w_to_hold;

    assign w_xfer    = din_valid & ~r_hold_full;
    assign w_adv     = (r_state == S_SHIFT) & en;
    assign w_last    = w_adv & (r_cnt == CW'(WIDTH - 1));
    // A transfer on the last-bit edge bypasses the hold and feeds the shifter directly
    assign w_to_hold = w_xfer & (r_state == S_SHIFT) & ~w_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_hold_full <= 1'b0;
            r_done      <= 1'b0;
            r_words     <= 8'd0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                r_words <= r_words + 8'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_shift <= din;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                default: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (r_hold_full) begin
                            r_shift     <= r_hold;
                            r_hold_full <= 1'b0;
                        end else if (w_xfer) begin
                            r_shift <= din;
                        end else begin
                            r_shift <= '0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        if (w_adv) begin
                            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                            r_cnt   <= r_cnt + CW'(1);
                        end
                        if (w_to_hold) begin
                            r_hold_full <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Holding data carries no reset; r_hold_full alone says whether it is meaningful
    always_ff @(posedge clk) begin
        if (w_to_hold) begin
            r_hold <= din;
        end
    end

    assign din_ready = ~r_hold_full;
    assign x_valid   = (r_state == S_SHIFT);
    assign x         = (r_state == S_SHIFT) & r_shift[WIDTH-1];
    assign done      = r_done;
    assign words     = r_words;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: a directed vector table, hand-written corner sequences,
// and random traffic checked against a word-queue reference model.
module tb_seq_serializer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         en;
    logic         x;
    logic         x_valid;
    logic         done;
    logic [7:0]   words;

    seq_serializer #(.WIDTH(W), .CW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .en        (en),
        .x         (x),
        .x_valid   (x_valid),
        .done      (done),
        .words     (words)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         dv;
        logic [W-1:0] d;
        logic         e;
        logic [11:0]  exp;  // {x, x_valid, din_ready, done, words}
    } vec_t;

    int nvec = 0;
    int nmis = 0;

    // Reference model: queue of accepted words, head word bit position, word count
    logic [W-1:0] mq[$];
    int           pos;
    logic         m_done;
    logic [7:0]   m_words;

    int xv_cnt;
    int done_cnt;
    int cyc;
    int acc;
    int done_cyc[$];

    task automatic model_reset();
        mq.delete();
        pos     = 0;
        m_done  = 1'b0;
        m_words = 8'd0;
    endtask

    task automatic model_step(input logic dv, input logic [W-1:0] d, input logic e);
        logic xfer;
        xfer   = dv && (mq.size() < 2);
        m_done = 1'b0;
        if (mq.size() > 0 && e) begin
            pos++;
            if (pos == W) begin
                void'(mq.pop_front());
                pos     = 0;
                m_done  = 1'b1;
                m_words = m_words + 8'd1;
            end
        end
        if (xfer) mq.push_back(d);
    endtask

    function automatic logic [11:0] model_out();
        logic [W-1:0] h;
        logic         ex;
        logic         busy;
        busy = (mq.size() > 0);
        h    = busy ? mq[0] : '0;
        ex   = busy ? h[W-1-pos] : 1'b0;
        return {ex, busy, logic'(mq.size() < 2), m_done, m_words};
    endfunction

    function automatic logic [11:0] dut_out();
        return {x, x_valid, din_ready, done, words};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nmis++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic clr_stats();
        xv_cnt   = 0;
        done_cnt = 0;
        cyc      = 0;
        acc      = 0;
        done_cyc.delete();
    endtask

    // Entered at a negedge; drives inputs, advances one edge, checks at the next negedge
    task automatic cycle(input logic dv, input logic [W-1:0] d, input logic e, input string tag);
        din_valid = dv;
        din       = d;
        en        = e;
        if (dv && din_ready) acc++;
        model_step(dv, d, e);
        @(posedge clk);
        @(negedge clk);
        check(tag, {20'd0, dut_out()}, {20'd0, model_out()});
        if (x_valid) xv_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        en        = 1'b0;
        rst       = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t vt[10];

    initial begin
        logic [W-1:0] b;
        rst       = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        en        = 1'b0;
        model_reset();
        clr_stats();
        @(negedge clk);
        @(negedge clk);
        check("reset_state", {20'd0, dut_out()}, {20'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0});
        rst = 1'b1;

        // Single word 8'hB4, en held high
        b = 8'hB4;
        vt[0] = '{1'b1, 8'hB4, 1'b1, {1'b1, 1'b1, 1'b1, 1'b0, 8'd0}};
        for (int i = 1; i < 8; i++)
            vt[i] = '{1'b0, 8'h00, 1'b1, {b[W-1-i], 1'b1, 1'b1, 1'b0, 8'd0}};
        vt[8] = '{1'b0, 8'h00, 1'b1, {1'b0, 1'b0, 1'b1, 1'b1, 8'd1}};
        vt[9] = '{1'b0, 8'h00, 1'b1, {1'b0, 1'b0, 1'b1, 1'b0, 8'd1}};
        for (int i = 0; i < 10; i++) begin
            din_valid = vt[i].dv;
            din       = vt[i].d;
            en        = vt[i].e;
            model_step(vt[i].dv, vt[i].d, vt[i].e);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("table[%0d]", i), {20'd0, dut_out()}, {20'd0, vt[i].exp});
        end

        // Back-to-back 96, 5A with din_valid held while the hold is full
        clr_stats();
        cycle(1'b1, 8'h96, 1'b1, "t2");
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'h5A, 1'b1, "t2");
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, "t2");
        check("t2_xvalid_bits", xv_cnt, 16);
        check("t2_done_count", done_cnt, 2);
        if (done_cnt == 2) check("t2_done_spacing", done_cyc[1] - done_cyc[0], 8);

        // Word F0 with en pattern 1,0,0,1,0,0,...
        clr_stats();
        cycle(1'b1, 8'hF0, 1'b1, "t3");
        for (int i = 0; i < 30; i++) cycle(1'b0, 8'h00, (i % 3) == 2, "t3");
        check("t3_done_count", done_cnt, 1);
        check("t3_xvalid_bits", xv_cnt, 24);

        // Bypass: next word offered exactly on the last-bit edge with hold empty
        clr_stats();
        cycle(1'b1, 8'hA5, 1'b1, "t4");
        for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1, "t4");
        cycle(1'b1, 8'h3C, 1'b1, "t4");
        for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1, "t4");
        check("t4_xvalid_bits", xv_cnt, 16);
        check("t4_done_count", done_cnt, 2);

        // Asynchronous reset mid-word with the hold full
        cycle(1'b1, 8'hC3, 1'b1, "t5");
        cycle(1'b1, 8'h77, 1'b1, "t5");
        cycle(1'b0, 8'h00, 1'b1, "t5");
        cycle(1'b0, 8'h00, 1'b1, "t5");
        check("t5_hold_full", {31'd0, din_ready}, 32'd0);
        #2 rst = 1'b0;
        #1 check("t5_async_reset", {20'd0, dut_out()}, {20'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0});
        model_reset();
        din_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        clr_stats();
        for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 1'b1, "t5");
        check("t5_no_done", done_cnt, 0);

        // 256 zero words: word counter wraps
        do_reset();
        clr_stats();
        for (int i = 0; i < 3000 && done_cnt < 256; i++)
            cycle(acc < 256, 8'h00, 1'b1, "t6");
        check("t6_done_count", done_cnt, 256);
        check("t6_words_wrap", {24'd0, words}, 32'd0);

        // Random traffic
        for (int i = 0; i < 2000; i++)
            cycle(($urandom % 10) < 7, W'($urandom), ($urandom % 4) != 0, "rand");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
